rgb_frame_gen: RTL
==================

# rgb_frame_gen

Parametrised synthetic video source that emits complete RGB frames with line/frame framing (`valid`, `lvalid`, `fvalid`, `sof`, `eof`) and pixel coordinates. It generalises the fixed-size test-pattern channel to:
- configurable resolution, blanking and channel width;
- six selectable patterns;
- a frame-count limit;
- downstream backpressure.

It sits at the head of the VFP pipeline, in place of the camera/BMP source, for both simulation and on-board self-test.

## Interface
- `DATA_WIDTH`, 8, bits per colour channel.
- `COORD_WIDTH`, 12, width of `o_x`/`o_y`; `IMG_WIDTH` and `IMG_HEIGHT` must each be ≤ 2^COORD_WIDTH.
- `IMG_WIDTH`, 1920, active pixels per line.
- `IMG_HEIGHT`, 1080, active lines per frame.
- `LVALID_OFFSET`, 10, horizontal blanking cycles after every line (≥1).
- `FRAME_GAP`, 5, vertical blanking cycles after the last line's blanking (≥1).

- `clk` in 1 — system clock.
- `reset` in 1 — synchronous, active-high reset.
- `i_enable` in 1 — start/continue generation.
- `i_mode` in 3 — pattern select.
- `i_color` in 3*DATA_WIDTH — solid colour, {R,G,B}.
- `i_num_frames` in 16 — frames to emit; 0 = continuous.
- `i_ready` in 1 — downstream accept.
- `o_valid`, `o_lvalid`, `o_fvalid`, `o_sof`, `o_eof` out 1 — framing.
- `o_red`, `o_green`, `o_blue` out DATA_WIDTH — pixel channels.
- `o_rgb` out 3*DATA_WIDTH — {red,green,blue}.
- `o_x`, `o_y` out COORD_WIDTH — pixel coordinate.
- `o_frame_cnt` out 16 — completed frames.
- `o_done` out 1 — frame limit reached.
- `o_checksum` out 32 — per-frame pixel sum (see Configuration).

## Operation
- FSM states: IDLE, ACTIVE, HBLANK, VBLANK, DONE.
- **IDLE:** all framing outputs are 0. When `i_enable`=1, go to ACTIVE at (0,0), latch `i_mode`/`i_color`, clear `o_frame_cnt`.
- **ACTIVE:** `o_valid`=`o_lvalid`=`o_fvalid`=1.
  - A transfer occurs when `o_valid & i_ready`.
  - On transfer, x increments. After x=IMG_WIDTH-1, go to HBLANK.
- **HBLANK:** `o_lvalid`=0, `o_fvalid`=1, lasts LVALID_OFFSET cycles.
  - Then y increments and the FSM returns to ACTIVE.
  - After the last line, go to VBLANK instead.
- **VBLANK:** `o_fvalid`=0, lasts FRAME_GAP cycles. At the end:
  - go to DONE if `i_num_frames`≠0 and `o_frame_cnt`==`i_num_frames`;
  - else go to IDLE if `i_enable`=0;
  - else start the next frame in ACTIVE, relatching mode and colour.
- **DONE:** `o_done`=1 until `i_enable`=0, then go to IDLE.
- `o_sof` = valid at (0,0). `o_eof` = valid at (IMG_WIDTH-1, IMG_HEIGHT-1). `o_frame_cnt` increments on the eof transfer.
- Deasserting `i_enable` mid-frame completes the current frame, then the FSM enters IDLE.
- Mode or colour changes mid-frame take effect at the next frame.
- Patterns, with max = all-ones, and all channel values truncated to DATA_WIDTH:
  - 0 — solid `i_color`.
  - 1 — horizontal ramp: R=G=B=x[DATA_WIDTH-1:0].
  - 2 — vertical ramp: R=G=B=y[DATA_WIDTH-1:0].
  - 3 — colour bars. Bar index = (x*8)/IMG_WIDTH. Bars in order: white, yellow, cyan, green, magenta, red, blue, black.
  - 4 — checkerboard: x[4]^y[4] gives white when 1, black when 0.
  - 5 — pixel counter. `o_rgb` = number of pixels transferred in the current frame, modulo 2^(3*DATA_WIDTH).
  - 6, 7 — same as 0.

## Timing
- All outputs are registered.
- Reset: state IDLE; every output is 0, including `o_frame_cnt`, `o_done` and `o_checksum`.
  - `reset` asserted mid-frame clears everything at the next edge.
  - No partial frame resumes.
- Latency: `i_enable` sampled high at edge N gives `o_valid`=`o_sof`=1 after edge N+1.
- Backpressure: while `o_valid & !i_ready`, all pixel, coordinate and framing outputs hold stable.
  - HBLANK and VBLANK counters are unaffected by `i_ready`.
- Frame period with `i_ready`=1: IMG_HEIGHT*(IMG_WIDTH+LVALID_OFFSET)+FRAME_GAP cycles.
- A new frame is started back-to-back from VBLANK; IDLE is not entered between frames.

## Configuration
- `PATTERN_CHECKSUM_EN` defined:
  - a 32-bit accumulator adds the zero-extended `o_rgb` on each transfer, modulo 2^32;
  - at the eof transfer, accumulator + last pixel is latched into `o_checksum` and the accumulator clears.
- `PATTERN_CHECKSUM_EN` undefined: `o_checksum` is tied to 0 and no accumulator is instantiated.

## Test plan
All scenarios use IMG_WIDTH=4, IMG_HEIGHT=2, LVALID_OFFSET=2, FRAME_GAP=3, DATA_WIDTH=8 unless noted.
- Mode 1, `i_ready`=1, `i_num_frames`=1:
  - 8 pixels; R=G=B=0,1,2,3 on each line;
  - `o_lvalid` low for 2 cycles after each line;
  - `o_sof` at (0,0), `o_eof` at (3,1);
  - `o_frame_cnt`=1 and `o_done`=1 after 15 cycles.
- Backpressure: `i_ready`=0 for 3 cycles while at (2,0):
  - `o_x`=2, `o_rgb`=0x020202 and `o_valid`=1 held;
  - exactly 8 transfers total; `o_eof` occurs 3 cycles later than in the first scenario.
- Mode 3 with IMG_WIDTH=16:
  - x=0–1 gives 0xFFFFFF; x=2–3 gives 0xFFFF00; x=4–5 gives 0x00FFFF;
  - x=14–15 gives 0x000000.
- Mode 5, `i_num_frames`=0:
  - `o_rgb` runs 0..7 in every frame;
  - `o_sof` recurs every 15 cycles;
  - `o_frame_cnt` increments 1,2,3,…; `o_done` stays 0.
- Reset mid-frame at (1,1):
  - the next cycle shows all outputs 0 and `o_frame_cnt`=0;
  - re-enabling restarts at (0,0) with `o_sof`.
- Mode 5, one frame: `o_checksum`=28 after eof with `PATTERN_CHECKSUM_EN` defined; 0 without it.

Source files
------------

// File: rtl/rgb_frame_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rgb_frame_gen : parametrised RGB test-pattern frame source with framing,
// coordinates, frame limit and backpressure. Optional: PATTERN_CHECKSUM_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
module rgb_frame_gen #(
  parameter int DATA_WIDTH    = 8,
  parameter int COORD_WIDTH   = 12,
  parameter int IMG_WIDTH     = 1920,
  parameter int IMG_HEIGHT    = 1080,
  parameter int LVALID_OFFSET = 10,
  parameter int FRAME_GAP     = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_enable,
  input  logic [2:0]                i_mode,
  input  logic [3*DATA_WIDTH-1:0]   i_color,
  input  logic [15:0]               i_num_frames,
  input  logic                      i_ready,
  output logic                      o_valid,
  output logic                      o_lvalid,
  output logic                      o_fvalid,
  output logic                      o_sof,
  output logic                      o_eof,
  output logic [DATA_WIDTH-1:0]     o_red,
  output logic [DATA_WIDTH-1:0]     o_green,
  output logic [DATA_WIDTH-1:0]     o_blue,
  output logic [3*DATA_WIDTH-1:0]   o_rgb,
  output logic [COORD_WIDTH-1:0]    o_x,
  output logic [COORD_WIDTH-1:0]    o_y,
  output logic [15:0]               o_frame_cnt,
  output logic                      o_done,
  output logic [31:0]               o_checksum
);

  localparam int PW = 3 * DATA_WIDTH;
  localparam logic [COORD_WIDTH-1:0] LAST_X  = COORD_WIDTH'(IMG_WIDTH - 1);
  localparam logic [COORD_WIDTH-1:0] LAST_Y  = COORD_WIDTH'(IMG_HEIGHT - 1);
  localparam logic [15:0]            HB_LAST = 16'(LVALID_OFFSET - 1);
  localparam logic [15:0]            VB_LAST = 16'(FRAME_GAP - 1);

  typedef enum logic [2:0] {IDLE, ACTIVE, HBLANK, VBLANK, DONE} state_t;

  state_t                 state, state_nxt;
  logic [COORD_WIDTH-1:0] x, y, x_nxt, y_nxt;
  logic [15:0]            bcnt, bcnt_nxt, frame_cnt_nxt;
  logic [2:0]             mode, mode_nxt;
  logic [PW-1:0]          color, color_nxt, pcnt, pcnt_nxt, rgb_nxt;
  logic                   arm, arm_nxt, xfer, latch;
  logic [COORD_WIDTH+2:0] xs;
  logic [2:0]             bar, bar_bits;

  always_comb begin
    state_nxt     = state;
    x_nxt         = x;
    y_nxt         = y;
    bcnt_nxt      = bcnt;
    frame_cnt_nxt = o_frame_cnt;
    pcnt_nxt      = pcnt;
    arm_nxt       = arm;
    latch         = 1'b0;
    xfer          = (state == ACTIVE) && i_ready;
    case (state)
      // Enable is sampled into arm first, giving one extra cycle before the first pixel.
      IDLE: begin
        if (arm) begin
          state_nxt = ACTIVE;
          x_nxt     = '0;
          y_nxt     = '0;
          pcnt_nxt  = '0;
          arm_nxt   = 1'b0;
        end else if (i_enable) begin
          arm_nxt       = 1'b1;
          latch         = 1'b1;
          frame_cnt_nxt = '0;
        end
      end
      ACTIVE: begin
        if (xfer) begin
          pcnt_nxt = pcnt + PW'(1);
          if (o_eof) frame_cnt_nxt = o_frame_cnt + 16'd1;
          if (x == LAST_X) begin
            state_nxt = HBLANK;
            x_nxt     = '0;
            bcnt_nxt  = '0;
          end else begin
            x_nxt = x + COORD_WIDTH'(1);
          end
        end
      end
      HBLANK: begin
        if (bcnt == HB_LAST) begin
          bcnt_nxt = '0;
          if (y == LAST_Y) begin
            state_nxt = VBLANK;
            y_nxt     = '0;
          end else begin
            state_nxt = ACTIVE;
            y_nxt     = y + COORD_WIDTH'(1);
          end
        end else begin
          bcnt_nxt = bcnt + 16'd1;
        end
      end
      VBLANK: begin
        if (bcnt == VB_LAST) begin
          bcnt_nxt = '0;
          if (i_num_frames != 16'd0 && o_frame_cnt == i_num_frames) begin
            state_nxt = DONE;
          end else if (!i_enable) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = ACTIVE;
            pcnt_nxt  = '0;
            latch     = 1'b1;
          end
        end else begin
          bcnt_nxt = bcnt + 16'd1;
        end
      end
      DONE: if (!i_enable) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    mode_nxt  = latch ? i_mode  : mode;
    color_nxt = latch ? i_color : color;
  end

  // Pattern is evaluated on the next coordinate so the pixel registers alongside it.
  always_comb begin
    xs  = {x_nxt, 3'b000};
    bar = 3'(xs / (COORD_WIDTH + 3)'(IMG_WIDTH));
    case (bar)
      3'd0:    bar_bits = 3'b111;
      3'd1:    bar_bits = 3'b110;
      3'd2:    bar_bits = 3'b011;
      3'd3:    bar_bits = 3'b010;
      3'd4:    bar_bits = 3'b101;
      3'd5:    bar_bits = 3'b100;
      3'd6:    bar_bits = 3'b001;
      default: bar_bits = 3'b000;
    endcase
    case (mode_nxt)
      3'd1:    rgb_nxt = {3{DATA_WIDTH'(x_nxt)}};
      3'd2:    rgb_nxt = {3{DATA_WIDTH'(y_nxt)}};
      3'd3:    rgb_nxt = {{DATA_WIDTH{bar_bits[2]}}, {DATA_WIDTH{bar_bits[1]}},
                          {DATA_WIDTH{bar_bits[0]}}};
      3'd4:    rgb_nxt = {PW{x_nxt[4] ^ y_nxt[4]}};
      3'd5:    rgb_nxt = pcnt_nxt;
      default: rgb_nxt = color_nxt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      x           <= '0;
      y           <= '0;
      bcnt        <= '0;
      mode        <= '0;
      color       <= '0;
      pcnt        <= '0;
      arm         <= 1'b0;
      o_valid     <= 1'b0;
      o_lvalid    <= 1'b0;
      o_fvalid    <= 1'b0;
      o_sof       <= 1'b0;
      o_eof       <= 1'b0;
      o_rgb       <= '0;
      o_frame_cnt <= '0;
      o_done      <= 1'b0;
    end else begin
      state       <= state_nxt;
      x           <= x_nxt;
      y           <= y_nxt;
      bcnt        <= bcnt_nxt;
      mode        <= mode_nxt;
      color       <= color_nxt;
      pcnt        <= pcnt_nxt;
      arm         <= arm_nxt;
      o_valid     <= (state_nxt == ACTIVE);
      o_lvalid    <= (state_nxt == ACTIVE);
      o_fvalid    <= (state_nxt == ACTIVE) || (state_nxt == HBLANK);
      o_sof       <= (state_nxt == ACTIVE) && (x_nxt == '0) && (y_nxt == '0);
      o_eof       <= (state_nxt == ACTIVE) && (x_nxt == LAST_X) && (y_nxt == LAST_Y);
      o_rgb       <= (state_nxt == ACTIVE) ? rgb_nxt : '0;
      o_frame_cnt <= frame_cnt_nxt;
      o_done      <= (state_nxt == DONE);
    end
  end

  assign o_x     = x;
  assign o_y     = y;
  assign o_red   = o_rgb[3*DATA_WIDTH-1:2*DATA_WIDTH];
  assign o_green = o_rgb[2*DATA_WIDTH-1:DATA_WIDTH];
  assign o_blue  = o_rgb[DATA_WIDTH-1:0];

`ifdef PATTERN_CHECKSUM_EN
  logic [31:0] acc;

  // The eof pixel is folded in directly so the frame sum is ready right after eof.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc        <= '0;
      o_checksum <= '0;
    end else if (xfer) begin
      if (o_eof) begin
        o_checksum <= acc + 32'(o_rgb);
        acc        <= '0;
      end else begin
        acc <= acc + 32'(o_rgb);
      end
    end
  end
`else
  assign o_checksum = '0;
`endif

endmodule
`default_nettype wire
